vga_pixel_fetch: RTL and testbench
==================================

// Module: vga_pixel_fetch
// PURPOSE
//  Downstream stage of vga_sync_generator: turns its timing (blank_n, HS, VS) into RGB pixels.
//  Prefetches frame-buffer words over a req/gnt + in-order rvalid read port into a small FIFO.
//  Pops one pixel per visible clock; re-aligns sync/blank to pixel data; sticky underflow flag.
// PARAMETERS
//  H_VISIBLE   800  visible pixels per line
//  V_VISIBLE   480  visible lines per frame; frame size = H_VISIBLE*V_VISIBLE words
//  FIFO_DEPTH  16   pixel FIFO entries, power of 2, >=4
//  DATA_W      24   pixel word {R[23:16],G[15:8],B[7:0]}
// PORTS
//  vga_clk      in   1      pixel clock
//  reset        in   1      asynchronous, active-high
//  blank_n_in   in   1      1 = visible pixel this cycle (from sync generator)
//  hs_in        in   1      horizontal sync, active-high
//  vs_in        in   1      vertical sync, active-high
//  mem_req      out  1      read request valid
//  mem_addr     out  32     word address, frame base = 0
//  mem_gnt      in   1      request accepted when mem_req & mem_gnt
//  mem_rvalid   in   1      read data valid, in request order, latency >=1
//  mem_rdata    in   DATA_W read data
//  vga_r/g/b    out  8 each pixel colour, registered
//  vga_blank_n  out  1      blank_n_in delayed 1 cycle
//  vga_hs       out  1      hs_in delayed 1 cycle
//  vga_vs       out  1      vs_in delayed 1 cycle
//  underflow    out  1      sticky: visible pixel requested with FIFO empty
// BEHAVIOUR
//  Reset: reset asynchronous, active-high; clock vga_clk. All outputs 0, FIFO empty,
//   counters 0, discard count 0. Memory model shares the same reset (no post-reset rvalid).
//  Credit: outstanding = accepted requests not yet returned. mem_req=1 iff
//   fifo_count+outstanding < FIFO_DEPTH and fetch_count < H_VISIBLE*V_VISIBLE and no flush.
//   While mem_req=1 and mem_gnt=0, mem_addr stays stable. On accept: mem_addr+1, fetch_count+1.
//  Return: mem_rvalid with discard_cnt=0 -> push mem_rdata, outstanding-1.
//   Overflow cannot occur by construction; an overflow attempt is an assertion failure.
//  Pop: blank_n_in=1 and FIFO not empty -> pop; next cycle vga_rgb = popped word.
//   blank_n_in=1 and FIFO empty -> vga_rgb=0 next cycle, underflow<=1 (held until reset).
//   blank_n_in=0 -> vga_rgb=0 next cycle, no pop.
//   Push and pop in the same cycle: count unchanged, both take effect.
//  Latency: pixel data, vga_blank_n, vga_hs, vga_vs all exactly 1 cycle after inputs.
//  Frame restart: vs_in rising edge (vs_in=1, vs_d=0) in cycle T -> at T+1: FIFO empty,
//   mem_addr=0, fetch_count=0, discard_cnt=outstanding (including a request accepted at T),
//   outstanding=0. mem_req forced 0 in cycle T (memory tolerates withdrawn unaccepted req).
//   While discard_cnt>0, each mem_rvalid is dropped and decrements discard_cnt; mem_req
//   stays 0 until discard_cnt=0. underflow is not cleared by restart.
//  End of frame: after H_VISIBLE*V_VISIBLE accepts, mem_req=0 until next restart.
//  Widths: fetch_count/mem_addr 32 bit, no wrap within a frame; FIFO pointers log2(DEPTH)+1.
// TESTING
//  1 Reset mid-fetch (outstanding=3) -> all outputs 0 next edge; mem_req=0 until reset low.
//  2 Zero-wait memory (gnt=1, latency 1), full 1056x524 frame with rdata=addr -> pixel n
//    at visible slot n shows {R,G,B}=n[23:0], all 384000 pixels, underflow=0.
//  3 gnt held 0 for 20 cycles with mem_req=1 -> mem_addr stable; never >16 in flight+queued.
//  4 Memory stalls 40 cycles during visible line -> underflow=1, vga_rgb=0 on starved
//    pixels, flag stays 1 through next frame.
//  5 VS rise with 5 outstanding reads -> 5 rvalids dropped, next request mem_addr=0,
//    first visible pixel of new frame = word 0.
//  6 Push+pop same cycle with FIFO full-1 and empty+1 -> count unchanged, order preserved.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch
// Sits behind the sync generator and turns its blank/sync timing into RGB
// pixels. Frame-buffer words are prefetched over a req/gnt read port (in-order
// rvalid) into a small FIFO. A visible cycle pops one word. Sync and blank are
// delayed one cycle so they stay aligned with the registered pixel. A rising
// edge on vs_in restarts the frame: the FIFO is flushed, the address returns
// to 0, and reads still in flight are counted out and dropped on return.
// The sticky underflow flag records any visible pixel that found the FIFO
// empty.

module vga_pixel_fetch #(
  parameter int H_VISIBLE  = 800,
  parameter int V_VISIBLE  = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 24
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              blank_n_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_blank_n,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              underflow
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam int          PW          = AW + 1;
  localparam logic [31:0] FRAME_WORDS = 32'(H_VISIBLE * V_VISIBLE);
  localparam logic [PW:0] CREDIT_MAX  = (PW + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     outstanding_q, outstanding_d;
  logic [PW-1:0]     discard_q, discard_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic              underflow_q, underflow_d;
  logic              blank_q, hs_q, vs_q;

  logic [PW-1:0]     fifo_count;
  logic [PW:0]       credit_used;
  logic              fifo_empty;
  logic              fifo_full;
  logic              vs_rise;
  logic              accept;
  logic              push;
  logic              drop;
  logic              pop;

  // The frame base is 0, so the fetch counter doubles as the read address.
  assign fifo_count  = wr_ptr_q - rd_ptr_q;
  assign fifo_empty  = (fifo_count == '0);
  assign fifo_full   = (fifo_count == PW'(FIFO_DEPTH));
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign vs_rise     = vs_in & ~vs_q;

  // Request only while queued plus in-flight words leave room in the FIFO.
  // The frame must not be fully fetched, and no stale reads may be draining.
  // Requests are withdrawn during the restart cycle and while reset is held.
  assign mem_req = ~reset & (credit_used < CREDIT_MAX) & (addr_q < FRAME_WORDS)
                 & (discard_q == '0) & ~vs_rise;
  assign accept  = mem_req & mem_gnt;
  assign push    = mem_rvalid & (discard_q == '0);
  assign drop    = mem_rvalid & (discard_q != '0);
  assign pop     = blank_n_in & ~fifo_empty;

  // Next-state: FIFO pointers, credit counters, pixel and sticky flag.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    wr_ptr_d      = wr_ptr_q + PW'(push);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    addr_d        = addr_q + 32'(accept);
    outstanding_d = outstanding_q + PW'(accept) - PW'(push);
    discard_d     = discard_q - PW'(drop);
    rgb_d         = pop ? fifo_mem[rd_ptr_q[AW-1:0]] : '0;
    underflow_d   = underflow_q | (blank_n_in & fifo_empty);

    if (vs_rise) begin
      // Every read not yet returned now belongs to the old frame. That
      // includes one accepted this cycle. Those reads are dropped when
      // their data comes back.
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      addr_d        = '0;
      outstanding_d = '0;
      discard_d     = discard_q - PW'(drop) + outstanding_q + PW'(accept) - PW'(push);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      addr_q        <= '0;
      rgb_q         <= '0;
      underflow_q   <= 1'b0;
      blank_q       <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      addr_q        <= addr_d;
      rgb_q         <= rgb_d;
      underflow_q   <= underflow_d;
      blank_q       <= blank_n_in;
      hs_q          <= hs_in;
      vs_q          <= vs_in;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge vga_clk) begin
    // NOTE: the storage array is not reset; the pointers alone decide which entries are valid.
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= mem_rdata;
    end
  end

  assign mem_addr    = addr_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_blank_n = blank_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign underflow   = underflow_q;

  // The credit rule keeps queued plus in-flight words within FIFO_DEPTH. A
  // push into a full FIFO, or a return with nothing in flight, means that
  // rule broke.
  fifo_overflow_a: assert property (@(posedge vga_clk) disable iff (reset)
    !(push && fifo_full && !pop));
  credit_underrun_a: assert property (@(posedge vga_clk) disable iff (reset)
    !(push && outstanding_q == '0));

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch
// Self-checking bench for vga_pixel_fetch on a reduced 16x6 raster.
// The bench generates the raster timing and models the memory: an in-order
// read queue with random grant and latency. A frame-level reference model
// tracks FIFO occupancy, frame epochs and pixel order, and computes every
// expected output.

module tb_vga_pixel_fetch;

  localparam int H_VIS   = 16;
  localparam int V_VIS   = 6;
  localparam int H_TOTAL = H_VIS + 8;
  localparam int V_TOTAL = V_VIS + 5;
  localparam int DEPTH   = 16;
  localparam int FRAME   = H_VIS * V_VIS;
  localparam int FR_CYC  = H_TOTAL * V_TOTAL;

  logic        vga_clk    = 1'b0;
  logic        reset      = 1'b0;
  logic        blank_n_in = 1'b0;
  logic        hs_in      = 1'b0;
  logic        vs_in      = 1'b0;
  logic        mem_gnt    = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [23:0] mem_rdata  = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_blank_n, vga_hs, vga_vs, underflow;

  vga_pixel_fetch #(
    .H_VISIBLE (H_VIS),
    .V_VISIBLE (V_VIS),
    .FIFO_DEPTH(DEPTH),
    .DATA_W    (24)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .blank_n_in (blank_n_in),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_blank_n(vga_blank_n),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .underflow  (underflow)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int addr;
    int epoch;
    int due;
  } req_t;

  int tests = 0;
  int fails = 0;

  // Memory model and stimulus knobs.
  req_t        pend[$];
  logic [31:0] salt;
  int          cyc;
  int          gnt_pct;
  int          lat_max;
  int          budget;
  int          stall_until;

  // Raster position of the cycle currently driven.
  int h, v;

  // Reference model state.
  int          epoch;
  int          avail;
  int          accepted;
  int          k;
  bit          prev_vs;
  bit          exp_uf;
  logic [23:0] exp_rgb;
  bit          exp_blank, exp_hs, exp_vs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int a);
    logic [31:0] t;
    t = (32'(a) * 32'h0019660D + 32'h3C6EF35F) ^ salt;
    return t[23:0];
  endfunction

  task automatic set_gnt(input int pct);
    gnt_pct = pct;
    mem_gnt = ($urandom_range(99) < pct) && (budget != 0);
  endtask

  task automatic drive();
    blank_n_in = (h < H_VIS) && (v < V_VIS);
    hs_in      = (h >= H_VIS + 2) && (h < H_VIS + 5);
    vs_in      = (v >= V_VIS + 2) && (v < V_VIS + 4);
    if (pend.size() > 0 && pend[0].due <= cyc && cyc >= stall_until) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pix(pend[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 24'($urandom);
    end
    mem_gnt = ($urandom_range(99) < gnt_pct) && (budget != 0);
  endtask

  // One pixel clock: check request side, advance the model, check pixel side.
  task automatic step();
    int   old_p, new_p;
    bit   vs_rise, exp_req, acc, pop_m, ret, ret_old;
    req_t r;
    #1;
    vs_rise = vs_in && !prev_vs;
    old_p = 0;
    new_p = 0;
    foreach (pend[i]) begin
      if (pend[i].epoch != epoch) old_p++;
      else new_p++;
    end
    exp_req = (new_p + avail < DEPTH) && (accepted < FRAME) && (old_p == 0) && !vs_rise;
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    chk("mem_addr", mem_addr, 32'(accepted));

    acc     = mem_req && mem_gnt;
    ret     = mem_rvalid;
    ret_old = ret && (pend.size() > 0) && (pend[0].epoch != epoch);
    pop_m   = blank_n_in && (avail > 0);
    exp_rgb = pop_m ? pix(k) : 24'h0;
    if (pop_m) begin
      k++;
      avail--;
    end else if (blank_n_in) begin
      exp_uf = 1'b1;
    end
    if (ret && pend.size() > 0) begin
      void'(pend.pop_front());
      if (!ret_old) avail++;
    end
    if (acc) begin
      r.addr  = accepted;
      r.epoch = epoch;
      r.due   = cyc + 1 + int'($urandom_range(lat_max - 1, 0));
      pend.push_back(r);
      accepted++;
      if (budget > 0) budget--;
    end
    if (vs_rise) begin
      epoch++;
      avail    = 0;
      accepted = 0;
      k        = 0;
    end
    exp_blank = blank_n_in;
    exp_hs    = hs_in;
    exp_vs    = vs_in;
    prev_vs   = vs_in;
    h++;
    if (h == H_TOTAL) begin
      h = 0;
      v++;
      if (v == V_TOTAL) v = 0;
    end

    @(posedge vga_clk);
    cyc++;
    #1;
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    chk("blank_n", 32'(vga_blank_n), 32'(exp_blank));
    chk("hs", 32'(vga_hs), 32'(exp_hs));
    chk("vs", 32'(vga_vs), 32'(exp_vs));
    chk("underflow", 32'(underflow), 32'(exp_uf));
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_hv(input int vv, input int hh);
    int guard;
    guard = 0;
    while (!(v == vv && h == hh) && guard < 2 * FR_CYC) begin
      step();
      guard++;
    end
    if (!(v == vv && h == hh)) begin
      tests++;
      fails++;
      $error("FAIL wait_hv: observed timeout expected raster position %0d/%0d", vv, hh);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    chk("rst_sync", 32'({vga_blank_n, vga_hs, vga_vs}), 32'h0);
    chk("rst_underflow", 32'(underflow), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    pend.delete();
    blank_n_in  = 1'b0;
    hs_in       = 1'b0;
    vs_in       = 1'b0;
    mem_rvalid  = 1'b0;
    mem_gnt     = 1'b1;
    stall_until = 0;
    budget      = -1;
    epoch       = 0;
    avail       = 0;
    accepted    = 0;
    k           = 0;
    prev_vs     = 1'b0;
    exp_uf      = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_hold_mem_req", 32'(mem_req), 32'h0);
    chk("rst_hold_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    @(posedge vga_clk);
    cyc++;
    #1;
    reset = 1'b0;
    h = 0;
    v = V_VIS;
    drive();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    salt    = $urandom;
    cyc     = 0;
    gnt_pct = 100;
    lat_max = 1;
    budget  = -1;
    #2;
    apply_reset();

    // Zero-wait memory over full frames: every pixel in order, no underflow.
    run(3 * FR_CYC);
    chk("zero_wait_no_underflow", 32'(underflow), 32'h0);

    // Grant withheld for 20 cycles right after a restart: address must hold.
    wait_hv(V_VIS + 2, 1);
    set_gnt(0);
    run(20);
    set_gnt(100);
    run(FR_CYC);
    chk("gnt_hold_no_underflow", 32'(underflow), 32'h0);

    // Random grant and latency across several frames.
    lat_max = 4;
    set_gnt(60);
    run(4 * FR_CYC);

    // Memory stalls 40 cycles mid visible line: starved pixels read 0 and the flag sticks.
    lat_max = 1;
    set_gnt(100);
    wait_hv(1, 4);
    stall_until = cyc + 40;
    run(2 * FR_CYC);
    chk("stall_underflow", 32'(underflow), 32'h1);
    run(FR_CYC);
    chk("stall_underflow_sticky", 32'(underflow), 32'h1);

    // Reset while three reads are outstanding.
    apply_reset();
    budget      = 3;
    stall_until = cyc + 1000;
    set_gnt(100);
    run(10);
    apply_reset();

    // VS rises with five reads outstanding: they are dropped, fetch restarts at 0.
    budget      = 5;
    stall_until = cyc + 60;
    set_gnt(100);
    run(60);
    budget = -1;
    set_gnt(100);
    run(2 * FR_CYC);
    chk("restart_no_underflow", 32'(underflow), 32'h0);

    // Closing random run.
    lat_max = 3;
    set_gnt(75);
    run(2 * FR_CYC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
